// File: rtl/ripple_add_seq_pkg.sv
// Shared types and constants for the nibble-serial
// wide adder/subtractor.
package ripple_add_seq_pkg;

    localparam int SLICE_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [SLICE_W-1:0] nib_t;

endpackage

// File: rtl/ripple_add_slice.sv
// Combinational 4-bit ripple-carry adder; c3 is the
// carry into the top bit, needed for signed overflow.
module ripple_add_slice
    import ripple_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i])
                      | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];
    assign c3   = c[SLICE_W-1];

endmodule

// File: rtl/ripple_add_seq.sv
// Nibble-serial add/sub sequencer: one 4-bit slice
// reused LSB-first with the carry held in a register.
module ripple_add_seq
    import ripple_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW = (NSLICE > 1)
                      ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic            carry;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    nib_t             s_a;
    nib_t             s_b;
    nib_t             s_sum;
    logic             s_cout;
    logic             s_c3;
    logic [WIDTH-1:0] res_nxt;

    // Subtract is a + ~b + ~cin through the same adder.
    always_comb begin
        b_eff = b;
        c_eff = cin;
        unique case (1'b1)
            (mode == MODE_SUB): begin
                b_eff = ~b;
                c_eff = ~cin;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_a = '0;
        s_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                s_a = opa[i*SLICE_W +: SLICE_W];
                s_b = opb[i*SLICE_W +: SLICE_W];
            end
        end
    end

    ripple_add_slice u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout),
        .c3   (s_c3)
    );

    always_comb begin
        res_nxt = result;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                res_nxt[i*SLICE_W +: SLICE_W] = s_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b_eff;
                        carry <= c_eff;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result <= res_nxt;
                    carry  <= s_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout  <= s_cout;
                        ovf   <= s_cout ^ s_c3;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_add_seq.sv
// Self-checking bench for ripple_add_seq against an
// integer-arithmetic reference model.
module tb_ripple_add_seq;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    int           n_busy;
    int           n_done;
    int           done_at;
    logic [W-1:0] o_res;
    logic         o_co;
    logic         o_ov;
    logic [W-1:0] h_res;
    logic         h_co;
    logic         h_ov;

    ripple_add_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Returns {ovf, cout, result} from true integer math.
    function automatic logic [W+1:0] model(
        input logic m, input logic [W-1:0] x,
        input logic [W-1:0] y, input logic c);
        longint ua, ub, sa, sb, u, s;
        logic co, ov;
        ua = longint'(x);
        ub = longint'(y);
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        if (m == 1'b0) begin
            u  = ua + ub + longint'(c);
            s  = sa + sb + longint'(c);
            co = (u >= (longint'(1) << W));
        end else begin
            u  = ua - ub - longint'(c);
            s  = sa - sb - longint'(c);
            co = (u >= 0);
        end
        ov = (s > ((longint'(1) << (W-1)) - 1))
          || (s < -(longint'(1) << (W-1)));
        return {ov, co, u[W-1:0]};
    endfunction

    task automatic run_op(input logic m,
        input logic [W-1:0] x, input logic [W-1:0] y,
        input logic c, input bit poke);
        @(negedge clk);
        mode = m; a = x; b = y; cin = c; start = 1'b1;
        n_busy = 0; n_done = 0; done_at = -1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NS + 4; k++) begin
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
                o_res = result; o_co = cout; o_ov = ovf;
            end
            a = W'($urandom);
            b = W'($urandom);
            if (poke && (k == 1 || k == NS)) begin
                start = 1'b1; mode = ~m; cin = ~c;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        h_res = result; h_co = cout; h_ov = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000",
                     {busy, done, cout, ovf});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result got=%h want=0000",
                     result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic         tm [6] = '{0, 1, 1, 1, 0, 1};
        logic [W-1:0] ta [6] = '{16'hFFFF, 16'h000D,
            16'h000D, 16'h0003, 16'h7FFF, 16'h8000};
        logic [W-1:0] tb [6] = '{16'h0001, 16'h0003,
            16'h0003, 16'h0005, 16'h0001, 16'h0001};
        logic         tc [6] = '{0, 0, 1, 0, 0, 0};
        logic [W-1:0] er [6] = '{16'h0000, 16'h000A,
            16'h0009, 16'hFFFE, 16'h8000, 16'h7FFF};
        logic         ec [6] = '{1, 1, 1, 0, 0, 1};
        logic         eo [6] = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            run_op(tm[i], ta[i], tb[i], tc[i], 1'b0);
            checks++;
            if ({o_ov, o_co, o_res} !==
                {eo[i], ec[i], er[i]}) begin
                errors++;
                $display("FAIL dir%0d got=%b/%b/%h want=%b/%b/%h",
                    i, o_ov, o_co, o_res, eo[i], ec[i], er[i]);
            end
            checks++;
            if (n_done !== 1 || done_at !== NS
                || n_busy !== NS) begin
                errors++;
                $display("FAIL dir%0d_tim got=%0d/%0d/%0d want=1/%0d/%0d",
                    i, n_done, done_at, n_busy, NS, NS);
            end
        end
    endtask

    task automatic test_random();
        logic         m, c;
        logic [W-1:0] x, y;
        logic [W+1:0] e;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom);
            c = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            if (i % 8 == 0) y = ~x;
            e = model(m, x, y, c);
            run_op(m, x, y, c, 1'b0);
            checks++;
            if ({o_ov, o_co, o_res} !== e) begin
                errors++;
                $display("FAIL rnd%0d m=%b a=%h b=%h c=%b got=%b/%b/%h want=%b/%b/%h",
                    i, m, x, y, c, o_ov, o_co, o_res,
                    e[W+1], e[W], e[W-1:0]);
            end
            checks++;
            if ({h_ov, h_co, h_res} !== e) begin
                errors++;
                $display("FAIL rnd%0d_hold got=%b/%b/%h want=%b/%b/%h",
                    i, h_ov, h_co, h_res,
                    e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_handshake();
        run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b1);
        checks++;
        if (o_res !== 16'h5556 || o_co !== 1'b0
            || o_ov !== 1'b0) begin
            errors++;
            $display("FAIL hs_result got=%h/%b/%b want=5556/0/0",
                     o_res, o_co, o_ov);
        end
        checks++;
        if (n_busy !== NS) begin
            errors++;
            $display("FAIL hs_busy_len got=%0d want=%0d",
                     n_busy, NS);
        end
        checks++;
        if (n_done !== 1 || done_at !== NS) begin
            errors++;
            $display("FAIL hs_done got=%0d@%0d want=1@%0d",
                     n_done, done_at, NS);
        end
        checks++;
        if (h_res !== 16'h5556) begin
            errors++;
            $display("FAIL hs_hold got=%h want=5556", h_res);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W+1:0] e;
        run_op(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        mode = 1'b0; a = 16'hABCD; b = 16'h1111;
        cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0000
            || result !== '0) begin
            errors++;
            $display("FAIL mid_reset got=%b/%h want=0000/0000",
                     {busy, done, cout, ovf}, result);
        end
        e = model(1'b1, 16'h0100, 16'h0101, 1'b0);
        run_op(1'b1, 16'h0100, 16'h0101, 1'b0, 1'b0);
        checks++;
        if ({o_ov, o_co, o_res} !== e || n_done !== 1) begin
            errors++;
            $display("FAIL post_reset got=%b/%b/%h n=%0d want=%b/%b/%h n=1",
                o_ov, o_co, o_res, n_done,
                e[W+1], e[W], e[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e;
        int got = 0;
        int last = -1;
        @(negedge clk);
        mode = 1'($urandom); a = W'($urandom);
        b = W'($urandom); cin = 1'($urandom);
        e = model(mode, a, b, cin);
        start = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if ({ovf, cout, result} !== e) begin
                    errors++;
                    $display("FAIL b2b%0d got=%b/%b/%h want=%b/%b/%h",
                        got, ovf, cout, result,
                        e[W+1], e[W], e[W-1:0]);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last !== NS + 2) begin
                        errors++;
                        $display("FAIL b2b_gap got=%0d want=%0d",
                                 cyc - last, NS + 2);
                    end
                end
                last = cyc;
                got++;
                mode = 1'($urandom); a = W'($urandom);
                b = W'($urandom); cin = 1'($urandom);
                e = model(mode, a, b, cin);
            end else if (busy) begin
                mode = 1'($urandom); a = W'($urandom);
                b = W'($urandom); cin = 1'($urandom);
            end
        end
        start = 1'b0;
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=5", got);
        end
        repeat (NS + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_add_seq.md
Name: ripple_add_seq

Overview:
Multi-cycle sequencer that drives one 4-bit ripple-carry adder/subtractor slice across a WIDTH-bit operand, one nibble per clock, LSB first. It chains the carry through a register between slices. This gives wide add/sub with only a 4-bit adder's area and depth, for use in narrow datapaths that need occasional wide arithmetic. It exposes a start/busy/done handshake and holds the registered result.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NSLICE, WIDTH/4, derived number of nibble slices; not overridable

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin)
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in (add) or borrow-in (sub), captured with operands
busy  output  1  high while slices are being computed (RUN)
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  registered sum/difference
cout  output  1  final carry out; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow of the final result

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; slice index=0; carry register=0. Reset overrides all other inputs, including mid-RUN; a partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at edge E0, capture a, b, mode and cin. Set the internal B operand to mode ? ~b : b. Set the carry register to mode ? ~cin : cin. Set index=0 and go to RUN. result is not cleared at capture; it is overwritten slice by slice.
- RUN, each edge: feed the captured A and B nibbles at [4*idx+3:4*idx] and the carry register to the 4-bit slice. Write the slice sum into result at the same nibble. The carry register takes the slice cout, and idx increments. On the edge where idx==NSLICE-1, also latch cout=slice cout and ovf=slice cout XOR carry-into-bit-3 of that slice, then go to DONE.
- busy=1 exactly in RUN, from the cycle after E0 through edge E0+NSLICE.
- DONE: done=1 for exactly one cycle, the cycle after edge E0+NSLICE. busy=0. Next edge returns to IDLE unconditionally.
- Latency: start accepted at E0 → done high after edge E0+NSLICE. Back-to-back throughput is one operation per NSLICE+2 cycles.
- start in RUN or DONE is ignored, not queued. Input changes to a, b, mode and cin after E0 have no effect on the in-flight operation.
- result, cout and ovf hold their values after DONE until the next accepted start begins overwriting them. cout and ovf update only at the final slice.
- Arithmetic is modulo 2^WIDTH. Subtraction is implemented as a + ~b + (~cin); no separate subtractor exists.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DONE), SLICE_W=4 constant, mode encoding constants (MODE_ADD=0, MODE_SUB=1).
- One sub-module, ripple_add_slice: purely combinational 4-bit ripple adder. Inputs are a[3:0], b[3:0] and cin. Outputs are sum[3:0], cout, and c3 (carry into bit 3, used for overflow).
- Sequencer owns all registers.

Test Plan:
- WIDTH=16, add, a=16'hFFFF, b=16'h0001, cin=0 → after 4 RUN cycles done pulses once; result=16'h0000, cout=1, ovf=0.
- Sub, a=16'h000D, b=16'h0003, cin=0 → result=16'h000A, cout=1 (no borrow), ovf=0. Repeat with cin=1 → result=16'h0009.
- Sub, a=16'h0003, b=16'h0005, cin=0 → result=16'hFFFE, cout=0 (borrow), ovf=0.
- Add, a=16'h7FFF, b=16'h0001, cin=0 → result=16'h8000, ovf=1, cout=0. Sub, a=16'h8000, b=16'h0001 → result=16'h7FFF, ovf=1.
- Handshake: pulse start again during RUN with different operands → ignored, first result intact, done exactly once. Check busy is high for exactly 4 cycles and done for exactly 1.
- Assert rst during the second RUN cycle → next cycle IDLE with busy=0, done=0, result=0, cout=0, ovf=0. A new start then completes correctly.
